// File: rtl/horner_seq.sv
// -----------------------------------------------------------------------------
// horner_seq.sv
//
// Purpose
//   Evaluates p(x) = c[D]*x^D + ... + c[1]*x + c[0] in signed Q16.16 using
//   Horner's rule. One shared mul_q16 multiplier is stepped once per clock:
//   acc <= sat32(acc*x + c[k-1]). Coefficients live in a small register file
//   written through a simple write port that is only open while idle, so they
//   cannot change under a running job.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   coef_we/addr/wdata  coefficient write port (c[addr] <= wdata, IDLE only)
//   in_valid/in_ready   job handshake; in_x = evaluation point, in_deg = D
//   out_valid/out_ready result handshake; out_y = p(x)
//   out_ovf             set if any add in this job saturated
//
// Also contains mul_q16, the signed Q16.16 multiplier shared by the sequencer.
// -----------------------------------------------------------------------------

// mul_q16: signed Q16.16 multiply. The 64-bit product is scaled back by 2^16
// with round-half-away-from-zero, then truncated to 32 bits (no saturation).
module mul_q16 (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] p
);
  logic signed [63:0] prod;
  logic        [63:0] mag;
  logic        [63:0] rnd;
  logic        [63:0] res;
  logic               neg;
  logic               unused_hi;

  always_comb begin
    prod = 64'(a) * 64'(b);
    neg  = prod[63];
    // Round the magnitude so ties move away from zero for both signs.
    mag  = neg ? 64'(-prod) : 64'(prod);
    rnd  = (mag + 64'h0000_0000_0000_8000) >> 16;
    res  = neg ? (~rnd + 64'd1) : rnd;
    p    = res[31:0];
  end

  // Upper bits are discarded on purpose: the result wraps, it does not saturate.
  assign unused_hi = ^res[63:32];
endmodule

module horner_seq #(
  parameter int MAX_DEG = 7,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [31:0]   coef_wdata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_x,
  input  logic [AW-1:0] in_deg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_y,
  output logic          out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]        coef [MAX_DEG+1];
  logic signed [31:0] acc;
  logic signed [31:0] x_q;
  logic [AW-1:0]      k;
  logic [31:0]        y_q;
  logic               ovf_q;

  logic [AW-1:0]      deg;
  logic               accept;
  logic               addr_ok;
  logic signed [31:0] m;
  logic [31:0]        c_next;
  logic [32:0]        sum;
  logic               sat;
  logic [31:0]        sum_sat;

  // Degree requests beyond the file size are clamped to the top coefficient.
  assign deg     = (int'(in_deg) > MAX_DEG) ? AW'(MAX_DEG) : in_deg;
  assign addr_ok = (int'(coef_addr) <= MAX_DEG);
  assign accept  = in_valid && in_ready;

  mul_q16 u_mul (
    .a (acc),
    .b (x_q),
    .p (m)
  );

  // One Horner step: sign-extend to 33 bits so the carry-out exposes overflow.
  always_comb begin
    c_next  = coef[k - AW'(1)];
    sum     = {m[31], m} + {c_next[31], c_next};
    sat     = (sum[32] != sum[31]);
    sum_sat = sat ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next-state logic
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept)           state_nxt = (deg == '0) ? S_DONE : S_RUN;
      S_RUN:  if (k == AW'(1))      state_nxt = S_DONE;
      S_DONE: if (out_ready)        state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. in_ready is gated by rst_n so it reads 0 for the whole
  // time reset is held, not just until the first clock.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE:  in_ready  = rst_n;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      x_q   <= '0;
      k     <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      x_q   <= in_x;
      acc   <= coef[deg];
      k     <= deg;
      ovf_q <= 1'b0;
      if (deg == '0) y_q <= coef[deg];
    end else if (state == S_RUN) begin
      acc <= sum_sat;
      k   <= k - AW'(1);
      if (sat)         ovf_q <= 1'b1;
      // Publish on the edge that enters DONE so out_y is valid with out_valid.
      if (k == AW'(1)) y_q   <= sum_sat;
    end
  end

  // Coefficient file. Writes are accepted only in IDLE; a job accepted on the
  // same edge still reads the old value because coef updates after the edge.
  // NOTE: the file is small and must read as zero after reset, so it is built
  // from resettable flops rather than a RAM macro (which cannot be reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= MAX_DEG; i++) coef[i] <= '0;
    end else if (coef_we && addr_ok && (state == S_IDLE)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  assign out_y   = y_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_horner_seq.sv
// -----------------------------------------------------------------------------
// tb_horner_seq: directed checks for horner_seq. The driver pushes the expected
// result (value, overflow flag, cycle on which out_valid must rise) into a
// scoreboard queue at issue time; a monitor on the falling edge checks the
// rise cycle and pops/compares on every out_valid & out_ready handshake.
// -----------------------------------------------------------------------------
module tb_horner_seq;

  localparam int MAX_DEG = 7;
  localparam int AW      = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [31:0]   coef_wdata;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_x;
  logic [AW-1:0] in_deg;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic          out_ovf;

  horner_seq #(.MAX_DEG(MAX_DEG), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_deg     (in_deg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    int          rise;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_v   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data on each handshake.
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
      else                check("latency_cycle", 32'(cyc), 32'(sb[0].rise));
    end
    prev_v = out_valid;
    if (out_valid && out_ready && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("out_y", out_y, e.y);
      check("out_ovf", 32'(out_ovf), 32'(e.ovf));
    end
  end

  task automatic wr_coef(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Issue one job; optionally perform a coefficient write on the accept edge.
  task automatic job(input logic [31:0] x, input logic [AW-1:0] d,
                     input logic [31:0] ey, input logic eovf, input int lat,
                     input bit wr, input logic [AW-1:0] wa, input logic [31:0] wd,
                     input bit wait_done);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    e.y = ey; e.ovf = eovf; e.rise = cyc + 1 + lat;
    sb.push_back(e);
    in_valid = 1'b1; in_x = x; in_deg = d;
    coef_we = wr; coef_addr = wa; coef_wdata = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
    // Inputs must be ignored after the accept edge.
    in_x = $urandom; in_deg = AW'($urandom);
    if (wait_done) wait_empty();
  endtask

  task automatic run(input logic [31:0] x, input logic [AW-1:0] d,
                     input logic [31:0] ey, input logic eovf, input int lat);
    job(x, d, ey, eovf, lat, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    in_valid = 1'b0; in_x = '0; in_deg = '0; out_ready = 1'b1;

    // Reset state
    #23;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: 3x^2 + 2x + 1 at x = 0.5 -> 2.75
    wr_coef(3'd0, 32'h0001_0000);
    wr_coef(3'd1, 32'h0002_0000);
    wr_coef(3'd2, 32'h0003_0000);
    run(32'h0000_8000, 3'd2, 32'h0002_C000, 1'b0, 2);

    // 2: degree 0 returns c0 on the accept edge
    wr_coef(3'd0, 32'h1234_5678);
    run(32'hDEAD_BEEF, 3'd0, 32'h1234_5678, 1'b0, 0);

    // 3: rounding half away from zero, both signs
    wr_coef(3'd1, 32'hFFFF_FFFF);
    wr_coef(3'd0, 32'h0000_0000);
    run(32'h0000_8000, 3'd1, 32'hFFFF_FFFF, 1'b0, 1);
    wr_coef(3'd1, 32'h0000_0001);
    run(32'h0000_8000, 3'd1, 32'h0000_0001, 1'b0, 1);

    // 4: positive and negative saturation, then a clean job clears ovf
    wr_coef(3'd1, 32'h7FFF_0000);
    wr_coef(3'd0, 32'h7FFF_0000);
    run(32'h0001_0000, 3'd1, 32'h7FFF_FFFF, 1'b1, 1);
    wr_coef(3'd1, 32'h8000_0000);
    wr_coef(3'd0, 32'h8000_0000);
    run(32'h0001_0000, 3'd1, 32'h8000_0000, 1'b1, 1);
    wr_coef(3'd1, 32'h0001_0000);
    wr_coef(3'd0, 32'h0000_0000);
    run(32'h0001_0000, 3'd1, 32'h0001_0000, 1'b0, 1);

    // Write on the accept edge: job sees old c0, next job sees new c0
    wr_coef(3'd0, 32'h0000_1111);
    job(32'h0, 3'd0, 32'h0000_1111, 1'b0, 0, 1'b1, 3'd0, 32'h0000_2222, 1'b1);
    run(32'h0, 3'd0, 32'h0000_2222, 1'b0, 0);

    // Maximum degree: c[k] = k, x = 1.0 -> 0+1+...+7 = 28.0
    for (int i = 0; i <= MAX_DEG; i++) wr_coef(AW'(i), 32'(i) << 16);
    run(32'h0001_0000, 3'd7, 32'h001C_0000, 1'b0, 7);

    // 5: backpressure; a write during the stall is dropped
    wr_coef(3'd1, 32'h0001_0000);
    wr_coef(3'd0, 32'h0000_0000);
    out_ready = 1'b0;
    job(32'h0002_0000, 3'd1, 32'h0002_0000, 1'b0, 1, 1'b0, '0, '0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 32'h0005_0000;
      end
      @(posedge clk); #1;
      coef_we = 1'b0;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_y", out_y, 32'h0002_0000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    wait_empty();
    run(32'h0002_0000, 3'd1, 32'h0002_0000, 1'b0, 1);

    // 6: reset in the middle of a degree-7 job (k = 4)
    for (int i = 0; i <= MAX_DEG; i++) wr_coef(AW'(i), 32'(i + 1) << 16);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_x = 32'h0001_0000; in_deg = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rel_in_ready", 32'(in_ready), 32'd1);
    check("midrst_rel_out_valid", 32'(out_valid), 32'd0);
    check("midrst_rel_out_y", out_y, 32'd0);
    repeat (10) @(negedge clk);
    check("midrst_no_result", 32'(out_valid), 32'd0);
    // Coefficients were cleared by reset
    run(32'h0001_0000, 3'd7, 32'h0000_0000, 1'b0, 7);
    run(32'h0001_0000, 3'd0, 32'h0000_0000, 1'b0, 0);
    // And a fresh job works: 1.0*3.0 + 0.5 = 3.5
    wr_coef(3'd1, 32'h0001_0000);
    wr_coef(3'd0, 32'h0000_8000);
    run(32'h0003_0000, 3'd1, 32'h0003_8000, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
